// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the sequence-detector front end.
// Frame length depends on SEQ_SER_PARITY_EN (adds one even-parity bit per word).
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_MAX = 32;

  function automatic int frame_len(input int width);
`ifdef SEQ_SER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/seq_det_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector: MSB-first, zero bubble between words.
// Optional even-parity bit after each word when SEQ_SER_PARITY_EN is defined.
//
// Handshake: a word transfers on a rising edge where din_valid && din_ready;
// din_ready depends only on state/counter, never on din_valid.
module seq_det_bit_serializer
  import seq_det_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output ser_state_t       dbg_state
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  ser_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;

  ser_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic             w_fill;

  // The bit on the wire is always the shift register MSB; the register is
  // cleared on the way back to IDLE so bit_out reads 0 there.
`ifdef SEQ_SER_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (w_xfer) begin
      r_par <= ^din;
    end
  end

  // Parity enters at the LSB and reaches the MSB exactly after WIDTH shifts.
  assign w_fill = r_par;
`else
  assign w_fill = 1'b0;
`endif

  assign w_last  = (r_cnt == CNT_LAST);
  assign w_ready = (r_state == IDLE) || ((r_state == SHIFT) && w_last);
  assign w_xfer  = din_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    if (w_xfer) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = '0;
      w_shift_nxt = din;
    end else if (r_state == SHIFT) begin
      if (w_last) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
      end else begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_shift_nxt = {r_shift[WIDTH-2:0], w_fill};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  assign din_ready = w_ready;
  assign bit_out   = r_shift[WIDTH-1];
  assign bit_valid = (r_state == SHIFT);
  assign busy      = (r_state == SHIFT);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_det_bit_serializer.sv
// Bench for seq_det_bit_serializer: vector table, directed corner sequences and
// random traffic checked against a bit-queue model (handles SEQ_SER_PARITY_EN).
module tb_seq_det_bit_serializer;
  import seq_det_pkg::*;

  localparam int W  = 8;
  localparam int FL = frame_len(W);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         bit_out;
  logic         bit_valid;
  logic         busy;
  ser_state_t   dbg_state;

  seq_det_bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int         n_total = 0;
  int         n_pass  = 0;
  logic [0:0] exp_q[$];   // front = bit expected on the wire this cycle
  bit         init_done = 1'b0;

  typedef struct {
    logic         r;
    logic         v;
    logic [W-1:0] d;
    logic         chk_rdy;
    logic         e_rdy;
    logic         e_vld;
    logic         e_bit;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push_frame(input logic [W-1:0] d);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SEQ_SER_PARITY_EN
    exp_q.push_back(^d);
`endif
  endfunction

  // ---------------- driver: one clock cycle, model-checked ----------------
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      output logic rdy, output logic vld, output logic b);
    logic m_rdy;
    rst       = r;
    din_valid = v;
    din       = d;
    #1;
    m_rdy = (exp_q.size() <= 1);
    rdy   = din_ready;
    if (init_done) check("din_ready", din_ready, m_rdy);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (v && m_rdy) push_frame(d);
    end
    init_done = 1'b1;
    #1;
    check("bit_valid", bit_valid, exp_q.size() > 0);
    check("bit_out", bit_out, (exp_q.size() > 0) ? exp_q[0] : 1'b0);
    check("busy", busy, exp_q.size() > 0);
    check("dbg_state", dbg_state, (exp_q.size() > 0) ? SHIFT : IDLE);
    vld = bit_valid;
    b   = bit_out;
    @(negedge clk);
  endtask

  task automatic send_collect(input logic [W-1:0] d, output logic [8:0] bits);
    logic rdy, vld, b;
    bits = '0;
    step(1'b0, 1'b1, d, rdy, vld, b);
    bits = {bits[7:0], b};
    for (int i = 1; i < FL; i++) begin
      step(1'b0, 1'b0, '0, rdy, vld, b);
      bits = {bits[7:0], b};
    end
    step(1'b0, 1'b0, '0, rdy, vld, b);
    check("frame_end_valid", vld, 1'b0);
  endtask

  task automatic add_vec(input logic r, input logic v, input logic [W-1:0] d,
                         input logic chk_rdy, input logic e_rdy, input logic e_vld, input logic e_bit);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.chk_rdy = chk_rdy;
    x.e_rdy = e_rdy; x.e_vld = e_vld; x.e_bit = e_bit;
    tbl.push_back(x);
  endtask

  // ---------------- test ----------------
  initial begin
    logic        rdy, vld, b;
    logic [4:0]  hist;
    int          nsince, hits, hit_pos, nbits;
    int          xf, gap, rdy_hi_mid;
    logic [17:0] got;
    logic [8:0]  bits;
    logic        r, v;
    logic [W-1:0] d;

    rst = 1'b1; din_valid = 1'b0; din = '0;
    @(negedge clk);

    // reset release, then single word 8'h92
    add_vec(1, 0, 8'h00, 0, 0, 0, 0);
    add_vec(1, 0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 0, 8'h00, 1, 1, 0, 0);
    add_vec(0, 1, 8'h92, 1, 1, 1, 1);
    add_vec(0, 0, 8'h00, 1, 0, 1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 1, 1);
    add_vec(0, 0, 8'h00, 1, 0, 1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 1, 0);
    add_vec(0, 0, 8'h00, 1, 0, 1, 1);
    add_vec(0, 0, 8'h00, 1, 0, 1, 0);
`ifdef SEQ_SER_PARITY_EN
    add_vec(0, 0, 8'h00, 1, 0, 1, 1);
    add_vec(0, 0, 8'h00, 1, 1, 0, 0);
`else
    add_vec(0, 0, 8'h00, 1, 1, 0, 0);
`endif
    add_vec(0, 0, 8'h00, 1, 1, 0, 0);

    hist = '0; nsince = 0; hits = 0; hit_pos = 0; nbits = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, rdy, vld, b);
      if (tbl[i].chk_rdy) check($sformatf("tbl[%0d].ready", i), rdy, tbl[i].e_rdy);
      check($sformatf("tbl[%0d].valid", i), vld, tbl[i].e_vld);
      check($sformatf("tbl[%0d].bit", i), b, tbl[i].e_bit);
      if (vld) begin
        // non-overlapping 10010 detector fed from the stream
        hist = {hist[3:0], b};
        nbits++;
        nsince++;
        if (nsince >= 5 && hist == 5'b10010) begin
          hits++;
          hit_pos = nbits;
          nsince = 0;
        end
      end
    end
    check("det_hits", hits, 1);
    check("det_pos", hit_pos, 5);

    // back-to-back A5 then 3C with din_valid held high
    xf = 0; gap = 0; rdy_hi_mid = 0; got = '0;
    for (int i = 0; i < 2 * FL + 2; i++) begin
      v = (xf < 2);
      d = (xf == 0) ? 8'hA5 : 8'h3C;
      step(1'b0, v, d, rdy, vld, b);
      if (v && rdy) xf++;
      if (i >= 1 && i <= FL - 1 && rdy) rdy_hi_mid++;
      if (i == FL) check("b2b_ready_last_bit", rdy, 1'b1);
      if (i < 2 * FL) begin
        if (!vld) gap++;
        got = {got[16:0], b};
      end
    end
    check("b2b_transfers", xf, 2);
    check("b2b_gaps", gap, 0);
    check("b2b_ready_mid_frame", rdy_hi_mid, 0);
`ifdef SEQ_SER_PARITY_EN
    check("b2b_bits", got, {8'hA5, 1'b0, 8'h3C, 1'b0});
`else
    check("b2b_bits", got, 18'h0A53C);
`endif

    // stall: three idle cycles, next word starts one cycle after its transfer
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 8'h00, rdy, vld, b);
      check("stall_idle_valid", vld, 1'b0);
    end
    step(1'b0, 1'b1, 8'hC3, rdy, vld, b);
    check("stall_restart_valid", vld, 1'b1);
    check("stall_restart_msb", b, 1'b1);
    for (int i = 1; i < FL + 1; i++) step(1'b0, 1'b0, 8'h00, rdy, vld, b);

    // reset in the middle of 8'hFF, simultaneous transfer attempt dropped
    step(1'b0, 1'b1, 8'hFF, rdy, vld, b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, rdy, vld, b);
    check("rmf_4th_bit", {vld, b}, 2'b11);
    step(1'b1, 1'b1, 8'hAA, rdy, vld, b);
    check("rmf_valid", vld, 1'b0);
    check("rmf_bit", b, 1'b0);
    send_collect(8'h81, bits);
`ifdef SEQ_SER_PARITY_EN
    check("rmf_new_word", bits, 9'h102);
    send_collect(8'h07, bits);
    check("parity_07", bits, 9'h00F);
    send_collect(8'h03, bits);
    check("parity_03", bits, 9'h006);
`else
    check("rmf_new_word", bits, 9'h081);
`endif

    // random traffic against the model
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = W'($urandom);
      step(r, v, d, rdy, vld, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
